// File: rtl/mmm_mul_seq.sv
// mmm_mul_seq: iterative a*b+c, one OBW-bit limb of b per cycle through a single IDW x OBW multiplier,
// valid/ready on both sides, optional early exit once the remaining b limbs are zero.
module mmm_mul_seq #(
   parameter int IDW        = 90,
   parameter int OBW        = 16,
   parameter bit EARLY_EXIT = 1
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [IDW-1:0]   i_a,
   input  logic [IDW-1:0]   i_b,
   input  logic [IDW-1:0]   i_c,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [2*IDW-1:0] o_res,
   output logic             o_busy
);
   localparam int ODW = 2*IDW;
   localparam int NB  = (IDW + OBW - 1) / OBW;
   localparam int BW  = NB*OBW;
   localparam int CW  = NB > 1 ? $clog2(NB) : 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t             state;
   logic [IDW-1:0]     a;
   logic [BW-1:0]      b;
   logic [ODW-1:0]     acc;
   logic [CW-1:0]      cnt;
   logic [IDW+OBW-1:0] pp;
   logic [ODW-1:0]     acc_nxt;
   logic               last;
   // contributions shifted past ODW are always zero, so truncation is safe
   always_comb begin
      pp      = {{OBW{1'b0}}, a} * {{IDW{1'b0}}, b[OBW-1:0]};
      acc_nxt = acc + (ODW'(pp) << (OBW*32'(cnt)));
      last    = cnt == CW'(NB-1) || (EARLY_EXIT && (b >> OBW) == '0);
   end
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state   <= IDLE;
         a       <= '0;
         b       <= '0;
         acc     <= '0;
         cnt     <= '0;
         o_valid <= 1'b0;
         o_res   <= '0;
         o_busy  <= 1'b0;
         o_ready <= 1'b1;
      end else begin
         case (state)
            IDLE: if (i_valid && o_ready) begin
               a       <= i_a;
               b       <= BW'(i_b);
               acc     <= ODW'(i_c);
               cnt     <= '0;
               state   <= CALC;
               o_ready <= 1'b0;
               o_busy  <= 1'b1;
            end
            CALC: begin
               acc <= acc_nxt;
               b   <= b >> OBW;
               cnt <= cnt + 1'b1;
               if (last) begin
                  state   <= DONE;
                  o_valid <= 1'b1;
                  o_res   <= acc_nxt;
               end
            end
            DONE: if (i_ready) begin
               state   <= IDLE;
               o_valid <= 1'b0;
               o_busy  <= 1'b0;
               o_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mmm_mul_seq.sv
// tb_mmm_mul_seq: scoreboard bench over four parameterisations of mmm_mul_seq;
// drivers push expected result and latency, one monitor checks every output handshake.
module tb_mmm_mul_seq;
   typedef struct {logic [179:0] res; int lat;} exp_t;
   localparam logic [89:0]  ONES = '1;
   localparam logic [179:0] MAXR = {ONES, 90'd0};
   logic          i_clk = 1'b0;
   logic          i_rstn = 1'b1;
   logic [3:0]    vin = '0;
   logic [3:0]    iready = '1;
   logic [3:0]    rdy, ov, busy;
   logic [89:0]   ai [4];
   logic [89:0]   bi [4];
   logic [89:0]   ci [4];
   logic [179:0]  r0, r1;
   logic [127:0]  r2;
   logic [33:0]   r3;
   logic [179:0]  res [4];
   logic [179:0]  hold_res [4];
   int            checks = 0, errors = 0, cyc = 0;
   int            acc_c [4];
   bit            seen [4];
   bit            hold [4];
   bit            drop [4];
   exp_t          sb [4][$];
   exp_t          e;

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;
   always_comb begin
      res[0] = r0;
      res[1] = r1;
      res[2] = 180'(r2);
      res[3] = 180'(r3);
   end

   mmm_mul_seq #(.IDW(90), .OBW(16), .EARLY_EXIT(1)) u0 (.i_clk(i_clk), .i_rstn(i_rstn), .i_valid(vin[0]), .o_ready(rdy[0]),
      .i_a(ai[0]), .i_b(bi[0]), .i_c(ci[0]), .o_valid(ov[0]), .i_ready(iready[0]), .o_res(r0), .o_busy(busy[0]));
   mmm_mul_seq #(.IDW(90), .OBW(16), .EARLY_EXIT(0)) u1 (.i_clk(i_clk), .i_rstn(i_rstn), .i_valid(vin[1]), .o_ready(rdy[1]),
      .i_a(ai[1]), .i_b(bi[1]), .i_c(ci[1]), .o_valid(ov[1]), .i_ready(iready[1]), .o_res(r1), .o_busy(busy[1]));
   mmm_mul_seq #(.IDW(64), .OBW(24), .EARLY_EXIT(1)) u2 (.i_clk(i_clk), .i_rstn(i_rstn), .i_valid(vin[2]), .o_ready(rdy[2]),
      .i_a(ai[2][63:0]), .i_b(bi[2][63:0]), .i_c(ci[2][63:0]), .o_valid(ov[2]), .i_ready(iready[2]), .o_res(r2), .o_busy(busy[2]));
   mmm_mul_seq #(.IDW(17), .OBW(17), .EARLY_EXIT(0)) u3 (.i_clk(i_clk), .i_rstn(i_rstn), .i_valid(vin[3]), .o_ready(rdy[3]),
      .i_a(ai[3][16:0]), .i_b(bi[3][16:0]), .i_c(ci[3][16:0]), .o_valid(ov[3]), .i_ready(iready[3]), .o_res(r3), .o_busy(busy[3]));

   task automatic check(input bit ok, input string name, input int k, input logic [179:0] act, input logic [179:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s dut=%0d got=%0h want=%0h", name, k, act, exp);
      end
   endtask

   task automatic step(input int k, input bit rnd);
      @(posedge i_clk);
      #1;
      if (rnd) iready[k] = $urandom_range(0, 2) != 0;
   endtask

   task automatic drive(input int k, input logic [89:0] a, input logic [89:0] b, input logic [89:0] c,
                        input logic [179:0] r, input int lat, input bit rnd);
      bit got = 0;
      ai[k] = a;
      bi[k] = b;
      ci[k] = c;
      vin[k] = 1'b1;
      sb[k].push_back('{r, lat});
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge i_clk);
         got = rdy[k];
         step(k, rnd);
      end
      vin[k] = 1'b0;
      if (!got) check(0, "accept_timeout", k, 0, 1);
   endtask

   task automatic wait_idle();
      int i = 0;
      while (i < 500 && (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() != 0 || ov != '0)) begin
         @(posedge i_clk);
         #1;
         i++;
      end
      if (i == 500) check(0, "drain_timeout", -1, 0, 0);
   endtask

   task automatic run_rand(input int k, input int n);
      logic [89:0] a, c;
      logic [71:0] b;
      int lat;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) step(k, 1);
         a = 90'({$urandom(), $urandom(), $urandom()});
         c = 90'({$urandom(), $urandom(), $urandom()});
         b = 72'({$urandom(), $urandom()} >> $urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0) b = '0;
         lat = 1;
         if (k == 2) begin
            a = 90'(a[63:0]);
            c = 90'(c[63:0]);
            for (int j = 0; j < 3; j++) if (b[24*j +: 24] != '0) lat = j + 1;
         end else begin
            a = 90'(a[16:0]);
            c = 90'(c[16:0]);
            b = 72'(b[16:0]);
         end
         drive(k, a, 90'(b), c, 180'(a) * 180'(b) + 180'(c), lat, 1);
      end
      iready[k] = 1'b1;
      for (int i = 0; i < 100 && sb[k].size() != 0; i++) step(k, 0);
      if (sb[k].size() != 0) check(0, "rand_drain", k, 180'(sb[k].size()), 0);
   endtask

   always @(negedge i_clk) begin
      for (int k = 0; k < 4; k++) begin
         if (!i_rstn) begin
            sb[k].delete();
            seen[k] = 0;
            hold[k] = 0;
            drop[k] = 0;
         end else begin
            if (hold[k]) check(ov[k] && res[k] == hold_res[k], "hold_stable", k, res[k], hold_res[k]);
            if (drop[k]) check(!ov[k], "valid_drop", k, 180'(ov[k]), 0);
            hold[k] = 0;
            drop[k] = 0;
            if (vin[k] && rdy[k]) acc_c[k] = cyc;
            if (ov[k] && !seen[k]) begin
               seen[k] = 1;
               if (sb[k].size() == 0) check(0, "unexpected_valid", k, res[k], 0);
               else check(cyc - acc_c[k] - 1 == sb[k][0].lat, "latency", k, 180'(cyc - acc_c[k] - 1), 180'(sb[k][0].lat));
               check(!rdy[k] && busy[k], "busy_flags", k, 180'({rdy[k], busy[k]}), 180'(2'b01));
            end
            if (ov[k] && iready[k]) begin
               if (sb[k].size() == 0) check(0, "unexpected_result", k, res[k], 0);
               else begin
                  e = sb[k].pop_front();
                  check(res[k] == e.res, "result", k, res[k], e.res);
               end
               seen[k] = 0;
               drop[k] = 1;
            end else if (ov[k]) begin
               hold[k] = 1;
               hold_res[k] = res[k];
            end
         end
      end
   end

   initial begin
      int n;
      bit got;
      for (int k = 0; k < 4; k++) begin
         ai[k] = '0;
         bi[k] = '0;
         ci[k] = '0;
      end
      #1 i_rstn = 1'b0;
      #2;
      for (int k = 0; k < 4; k++) begin
         check(rdy[k] == 1'b1, "rst_ready", k, 180'(rdy[k]), 1);
         check(ov[k] == 1'b0, "rst_valid", k, 180'(ov[k]), 0);
         check(busy[k] == 1'b0, "rst_busy", k, 180'(busy[k]), 0);
         check(res[k] == '0, "rst_res", k, res[k], 0);
      end
      @(negedge i_clk);
      @(negedge i_clk);
      i_rstn = 1'b1;
      @(posedge i_clk);
      #1;
      // directed vectors, early-exit and full-length instances side by side
      fork
         drive(0, ONES, ONES, ONES, MAXR, 6, 0);
         drive(1, ONES, ONES, ONES, MAXR, 6, 0);
      join
      fork
         drive(0, 90'd3, 90'd5, 90'd7, 180'd22, 1, 0);
         drive(1, 90'd3, 90'd5, 90'd7, 180'd22, 6, 0);
      join
      fork
         drive(0, 90'd12345, 90'(1) << 80, 90'd0, 180'(12345) << 80, 6, 0);
         drive(1, 90'd12345, 90'(1) << 80, 90'd0, 180'(12345) << 80, 6, 0);
      join
      fork
         drive(0, ONES, 90'd0, 90'd99, 180'd99, 1, 0);
         drive(1, ONES, 90'd0, 90'd99, 180'd99, 6, 0);
      join
      fork
         drive(0, (90'(1) << 89) + 90'd1, 90'h10000, 90'd5, (180'(1) << 105) + (180'(1) << 16) + 180'd5, 2, 0);
         drive(1, (90'(1) << 89) + 90'd1, 90'h10000, 90'd5, (180'(1) << 105) + (180'(1) << 16) + 180'd5, 6, 0);
      join
      wait_idle();
      // backpressure: result held while a new operand waits unaccepted
      iready[0] = 1'b0;
      drive(0, 90'd6, 90'd7, 90'd8, 180'd50, 1, 0);
      n = 0;
      while (!ov[0] && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      if (!ov[0]) check(0, "bp_valid_timeout", 0, 0, 1);
      ai[0] = 90'd2;
      bi[0] = 90'd2;
      ci[0] = 90'd2;
      vin[0] = 1'b1;
      sb[0].push_back('{180'd6, 1});
      for (int i = 0; i < 10; i++) begin
         @(negedge i_clk);
         check(rdy[0] == 1'b0, "bp_ready_low", 0, 180'(rdy[0]), 0);
         check(ov[0] == 1'b1, "bp_valid_high", 0, 180'(ov[0]), 1);
      end
      @(posedge i_clk);
      #1 iready[0] = 1'b1;
      n = 0;
      got = 0;
      while (!got && n < 20) begin
         @(negedge i_clk);
         got = rdy[0];
         @(posedge i_clk);
         #1;
         n++;
      end
      vin[0] = 1'b0;
      check(got && n == 2, "bp_accept_gap", 0, 180'(n), 2);
      wait_idle();
      // reset during the third CALC cycle abandons the operation
      ai[0] = ONES;
      bi[0] = ONES;
      ci[0] = ONES;
      vin[0] = 1'b1;
      @(negedge i_clk);
      check(rdy[0] == 1'b1, "rst_test_ready", 0, 180'(rdy[0]), 1);
      @(posedge i_clk);
      #1 vin[0] = 1'b0;
      repeat (3) @(posedge i_clk);
      #1 i_rstn = 1'b0;
      #1;
      check(ov[0] == 1'b0, "midrst_valid", 0, 180'(ov[0]), 0);
      check(res[0] == '0, "midrst_res", 0, res[0], 0);
      check(rdy[0] == 1'b1, "midrst_ready", 0, 180'(rdy[0]), 1);
      check(busy[0] == 1'b0, "midrst_busy", 0, 180'(busy[0]), 0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rstn = 1'b1;
      @(posedge i_clk);
      #1;
      drive(0, 90'd2, 90'd3, 90'd1, 180'd7, 1, 0);
      wait_idle();
      fork
         run_rand(2, 500);
         run_rand(3, 500);
      join
      wait_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mmm_mul_seq.md
Name: mmm_mul_seq

Overview:
- Parametrised, handshaked, iterative limb multiply-accumulate unit. Computes o_res = i_a*i_b + i_c for unsigned IDW-bit operands.
- Processes one OBW-bit limb of B per cycle, using a single IDW x OBW multiplier and an accumulator instead of a full partial-product array.
- Serves as the area-reduced multiplier core for Montgomery datapaths, where the a*b+c form feeds reduction steps directly.
- Adds what the fixed 90-bit pipelined multiplier lacks:
  - width generality;
  - valid/ready flow control with backpressure;
  - a fused addend;
  - optional early exit on short B operands.

Parameters:
- IDW, 90, operand width of i_a, i_b and i_c (>=2).
- OBW, 16, B limb width processed per cycle (1..IDW).
- EARLY_EXIT, 1, 1 = finish as soon as all remaining B limbs are zero; 0 = always NB cycles.
- ODW, 2*IDW, result width (derived localparam, not overridable).
- NB, ceil(IDW/OBW), B limb count (derived; B is zero-padded to NB*OBW bits).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_valid  in  1  input operands valid.
- o_ready  out  1  block can accept operands (high only in IDLE).
- i_a  in  IDW  multiplicand.
- i_b  in  IDW  multiplier (limb-iterated).
- i_c  in  IDW  addend.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_res  out  ODW  a*b+c.
- o_busy  out  1  high in CALC or DONE.

Behaviour:
- Interface:
  - One clock domain, i_clk.
  - Reset i_rstn is asynchronous, active-low.
- Reset values:
  - State = IDLE, accumulator = 0, limb counter = 0, latched A/B = 0.
  - o_valid = 0, o_res = 0, o_busy = 0, o_ready = 1.
- Reset mid-operation:
  - Abandons the operation immediately. No result is produced.
  - The next operation after release is unaffected.
- FSM, states IDLE, CALC, DONE:
  - IDLE:
    - o_ready = 1.
    - On a rising edge with i_valid && o_ready: latch a = i_a and b = i_b zero-extended to NB*OBW bits; set acc = i_c zero-extended to ODW; set cnt = 0; go to CALC.
    - i_valid low: stay in IDLE.
  - CALC: every edge:
    - acc <= acc + ((a * b[OBW-1:0]) << (cnt*OBW));
    - b <= b >> OBW;
    - cnt <= cnt + 1.
    - Go to DONE when cnt == NB-1.
    - If EARLY_EXIT = 1, also go to DONE when (b >> OBW) == 0, i.e. the remaining limbs are zero.
    - Minimum one CALC cycle, including b = 0.
  - DONE:
    - o_valid = 1 and o_res = acc, held stable while i_ready = 0.
    - On o_valid && i_ready at an edge: go to IDLE. o_valid drops next cycle.
    - No new operand is accepted in DONE; o_ready = 0.
- Latency:
  - Accept edge T. o_valid rises after edge T+K, where K is the number of CALC cycles.
  - K = NB when EARLY_EXIT = 0.
  - K = index of the highest nonzero B limb + 1 (minimum 1) when EARLY_EXIT = 1.
  - Minimum issue interval is K+2 cycles.
- Arithmetic:
  - All unsigned.
  - The accumulator is ODW bits; no overflow is possible because (2^IDW-1)^2 + 2^IDW-1 < 2^ODW.
  - Partial products are IDW+OBW bits wide. Shifted contributions beyond ODW are provably zero and are truncated.
- Input side:
  - i_valid while o_ready = 0 is ignored; operands are not queued.
  - Upstream must hold i_valid and data until the handshake.
- Output side:
  - o_res keeps its last value outside DONE; it is meaningful only while o_valid = 1.

Test Plan:
- Max operands, defaults: a = b = c = 2^90-1 → o_res = 2^180-2^90; o_valid exactly 6 cycles after the accept edge; o_ready low throughout.
- Small B: a = 3, b = 5, c = 7 with EARLY_EXIT = 1 → o_res = 22 after 1 CALC cycle. Same stimulus with EARLY_EXIT = 0 → 22 after 6 cycles.
- Top limb only: a = 12345, b = 2^80, c = 0, EARLY_EXIT = 1 → o_res = 12345<<80 after 6 cycles. Also b = 0 → o_res = c after 1 cycle.
- Backpressure: hold i_ready = 0 for 10 cycles in DONE while driving i_valid = 1 with new operands → o_valid and o_res stable, o_ready = 0, new operands not accepted. Release i_ready → o_valid drops next cycle; the new operation is accepted the cycle after that.
- Reset mid-CALC: assert i_rstn low at CALC cycle 3 → all outputs return to reset values asynchronously. After release, a = 2, b = 3, c = 1 → o_res = 7.
- Parameter sweep: IDW = 64 with OBW = 24 (NB = 3) and IDW = 17 with OBW = 17 (NB = 1), both EARLY_EXIT settings, 1000 random operations with random i_valid/i_ready gaps → every result matches the a*b+c model, and latency matches the formula.
